// File: rtl/washer_pkg.sv
// Shared encodings for the washer plant interface: fault codes and motor FSM states.
package washer_pkg;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_VALVE   = 2'd1;
  localparam logic [1:0] FAULT_MOTOR   = 2'd2;
  localparam logic [1:0] FAULT_FILL_TO = 2'd3;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_FWD  = 2'd1,
    M_REV  = 2'd2,
    M_DEAD = 2'd3
  } motor_state_t;

endpackage

// File: rtl/washer_motor_fsm.sv
// Motor direction FSM with dead-time on reversal; outputs are registered with the state.
module washer_motor_fsm
  import washer_pkg::*;
#(
  parameter int DEADTIME = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fwd_req,
  input  logic rev_req,
  input  logic force_idle,
  output logic motor_fwd,
  output logic motor_rev
);

  localparam int CW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEADTIME - 1);

  motor_state_t  state;
  logic [CW-1:0] dcnt;
  logic          tgt_rev;
  logic          fwd_only, rev_only, nxt_tgt_rev, tgt_held;

  assign fwd_only    = fwd_req & ~rev_req;
  assign rev_only    = rev_req & ~fwd_req;
  // An exclusive request during dead-time retargets without touching the count.
  assign nxt_tgt_rev = rev_only ? 1'b1 : (fwd_only ? 1'b0 : tgt_rev);
  assign tgt_held    = nxt_tgt_rev ? rev_req : fwd_req;

  // State, dead-time count, target and drive outputs advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= M_IDLE;
      dcnt      <= '0;
      tgt_rev   <= 1'b0;
      motor_fwd <= 1'b0;
      motor_rev <= 1'b0;
    end else if (force_idle) begin
      state     <= M_IDLE;
      dcnt      <= '0;
      motor_fwd <= 1'b0;
      motor_rev <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          if (fwd_only) begin
            state     <= M_FWD;
            motor_fwd <= 1'b1;
          end else if (rev_only) begin
            state     <= M_REV;
            motor_rev <= 1'b1;
          end
        end
        M_FWD: begin
          if (rev_only) begin
            state     <= M_DEAD;
            tgt_rev   <= 1'b1;
            dcnt      <= '0;
            motor_fwd <= 1'b0;
          end else if (!fwd_req) begin
            state     <= M_IDLE;
            motor_fwd <= 1'b0;
          end
        end
        M_REV: begin
          if (fwd_only) begin
            state     <= M_DEAD;
            tgt_rev   <= 1'b0;
            dcnt      <= '0;
            motor_rev <= 1'b0;
          end else if (!rev_req) begin
            state     <= M_IDLE;
            motor_rev <= 1'b0;
          end
        end
        M_DEAD: begin
          tgt_rev <= nxt_tgt_rev;
          if (dcnt == DEAD_LAST) begin
            dcnt <= '0;
            if (tgt_held) begin
              state     <= nxt_tgt_rev ? M_REV : M_FWD;
              motor_fwd <= ~nxt_tgt_rev;
              motor_rev <= nxt_tgt_rev;
            end else begin
              state <= M_IDLE;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/washer_plant_if.sv
// Plant-side actuator interface: valve drives, saturating level model, fault latch, motor FSM.
module washer_plant_if
  import washer_pkg::*;
#(
  parameter int LEVEL_W      = 8,
  parameter int LEVEL_MAX    = 200,
  parameter int FILL_RATE    = 1,
  parameter int DRAIN_RATE   = 2,
  parameter int DEADTIME     = 3,
  parameter int FILL_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctrl_fill,
  input  logic               ctrl_release,
  input  logic               ctrl_forward,
  input  logic               ctrl_reverse,
  input  logic               clear_fault,
  output logic               valve_in,
  output logic               valve_out,
  output logic               motor_fwd,
  output logic               motor_rev,
  output logic [LEVEL_W-1:0] level,
  output logic               level_full,
  output logic               level_empty,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int TW = $clog2(FILL_TIMEOUT + 1);
  localparam logic [LEVEL_W:0]   MAX_X  = (LEVEL_W + 1)'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(LEVEL_MAX);
  localparam logic [TW-1:0]      TO_LIM = TW'(FILL_TIMEOUT);

  logic [TW-1:0]      to_cnt, to_nxt;
  logic [LEVEL_W:0]   lvl_up, lvl_dn;
  logic [LEVEL_W-1:0] lvl_nxt;
  logic               to_run, det_valve, det_motor, det_to, det_any, frz, clr_ok;

  // One extra bit on the level arithmetic: overflow past LEVEL_MAX and borrow below 0 are both visible.
  assign lvl_up = {1'b0, level} + (LEVEL_W + 1)'(FILL_RATE);
  assign lvl_dn = {1'b0, level} - (LEVEL_W + 1)'(DRAIN_RATE);

  assign to_run    = ctrl_fill & level_full;
  assign to_nxt    = to_run ? to_cnt + 1'b1 : '0;
  assign det_valve = ctrl_fill & ctrl_release;
  assign det_motor = ctrl_forward & ctrl_reverse;
  assign det_to    = to_run & (to_nxt >= TO_LIM);
  assign det_any   = ~fault & (det_valve | det_motor | det_to);
  // Frozen while latched and on the detecting edge, so the plant stops as the fault appears.
  assign frz       = fault | det_any;
  // A clear only takes while nothing that could raise a fault is still asserted.
  assign clr_ok    = fault & clear_fault & ~det_valve & ~det_motor & ~to_run;

  // Next level from the currently open valve, saturating at both ends.
  always_comb begin
    lvl_nxt = level;
    if (!frz) begin
      if (valve_in)       lvl_nxt = (lvl_up > MAX_X) ? MAX_L : lvl_up[LEVEL_W-1:0];
      else if (valve_out) lvl_nxt = lvl_dn[LEVEL_W] ? '0 : lvl_dn[LEVEL_W-1:0];
    end
  end

  // Valve drives, level with its flags, timeout counter and fault latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valve_in    <= 1'b0;
      valve_out   <= 1'b0;
      level       <= '0;
      level_full  <= 1'b0;
      level_empty <= 1'b1;
      fault       <= 1'b0;
      fault_code  <= FAULT_NONE;
      to_cnt      <= '0;
    end else begin
      valve_in    <= ~frz & ctrl_fill & ~ctrl_release & ~level_full;
      valve_out   <= ~frz & ctrl_release & ~ctrl_fill & ~level_empty;
      level       <= lvl_nxt;
      level_full  <= (lvl_nxt >= MAX_L);
      level_empty <= (lvl_nxt == '0);
      if (fault) begin
        if (clr_ok) begin
          fault      <= 1'b0;
          fault_code <= FAULT_NONE;
          to_cnt     <= '0;
        end
      end else begin
        to_cnt <= to_nxt;
        if (det_any) begin
          fault      <= 1'b1;
          fault_code <= det_valve ? FAULT_VALVE : (det_motor ? FAULT_MOTOR : FAULT_FILL_TO);
        end
      end
    end
  end

  washer_motor_fsm #(.DEADTIME(DEADTIME)) u_motor (
    .clk        (clk),
    .rst_n      (rst_n),
    .fwd_req    (ctrl_forward),
    .rev_req    (ctrl_reverse),
    .force_idle (frz),
    .motor_fwd  (motor_fwd),
    .motor_rev  (motor_rev)
  );

endmodule

// File: doc/washer_plant_if.md
Name: washer_plant_if

Overview:
- Plant-side actuator interface for the washing register machine.
- Consumes the controller's ctrl_fill/ctrl_release/ctrl_forward/ctrl_reverse commands and drives registered valve and motor outputs.
- Holds a saturating water-level model and returns level_full/level_empty sensor flags to the controller.
- Enforces motor dead-time and latches command-conflict faults. Sits between reg_machine and the physical (or emulated) washer.

Parameters:
- LEVEL_W, 8, width of the level counter.
- LEVEL_MAX, 200, full-tank level; must be less than 2^LEVEL_W.
- FILL_RATE, 1, level increment per cycle while valve_in=1.
- DRAIN_RATE, 2, level decrement per cycle while valve_out=1.
- DEADTIME, 3, cycles both motor outputs stay low on a direction change (≥1).
- FILL_TIMEOUT, 8, consecutive cycles ctrl_fill may stay high while level_full before a fault.

Ports:
- clk  input  1  system clock (1 kHz in the system bench)
- rst_n  input  1  asynchronous active-low reset
- ctrl_fill  input  1  controller fill request
- ctrl_release  input  1  controller drain request
- ctrl_forward  input  1  controller forward-spin request
- ctrl_reverse  input  1  controller reverse-spin request
- clear_fault  input  1  single-cycle fault clear
- valve_in  output  1  inlet valve drive
- valve_out  output  1  drain valve drive
- motor_fwd  output  1  motor forward drive
- motor_rev  output  1  motor reverse drive
- level  output  LEVEL_W  modelled water level
- level_full  output  1  level ≥ LEVEL_MAX
- level_empty  output  1  level == 0
- fault  output  1  latched fault
- fault_code  output  2  0 none, 1 valve conflict, 2 motor conflict, 3 fill timeout

Behaviour:
- Reset: clk with asynchronous active-low rst_n. All outputs 0 except level_empty=1. level=0, motor FSM in M_IDLE, timers at 0.
- Reset mid-operation: immediate (asynchronous) return to the reset values.
- All outputs are registered. A ctrl change appears on the drives after 1 cycle.
- valve_in next value: ctrl_fill & ~ctrl_release & ~level_full & ~fault.
- valve_out next value: ctrl_release & ~ctrl_fill & ~level_empty & ~fault.
- Level update:
  - valve_in=1: level ← min(level+FILL_RATE, LEVEL_MAX).
  - valve_out=1: level ← max(level−DRAIN_RATE, 0).
  - Arithmetic uses one extra bit internally; no wrap-around.
  - Flags are derived from the registered level, so they reflect the new level in the same cycle it updates.
- Motor FSM states:
  - M_IDLE: both motor outputs 0. ctrl_forward → M_FWD; ctrl_reverse → M_REV.
  - M_FWD: motor_fwd=1. Request dropped → M_IDLE. ctrl_reverse only → M_DEAD with target REV.
  - M_REV: symmetric to M_FWD.
  - M_DEAD: both outputs 0 for exactly DEADTIME cycles, then → target state if its request is still held, else → M_IDLE. A request for the opposite direction during M_DEAD retargets it without restarting the count.
  - M_IDLE→M_FWD/M_REV has no dead-time.
  - The FSM is never driven directly FWD↔REV.
- Faults, evaluated each cycle when fault=0:
  - ctrl_fill & ctrl_release → code 1.
  - ctrl_forward & ctrl_reverse → code 2.
  - Fill-timeout counter increments while ctrl_fill & level_full and resets otherwise. Reaching FILL_TIMEOUT → code 3.
- Fault priority for simultaneous faults: 1 > 2 > 3.
- Fault latching:
  - fault and fault_code are set the cycle after detection.
  - On setting a fault: both valves close, the motor FSM is forced to M_IDLE, and level holds.
  - Later faults do not overwrite the code.
- Fault clear:
  - clear_fault clears fault, fault_code and the timeout counter if no fault condition is present that cycle.
  - Otherwise the clear is ignored.
  - clear_fault with fault=0 has no effect.

Decomposition:
- Package washer_pkg holds:
  - fault-code localparams FAULT_NONE, FAULT_VALVE, FAULT_MOTOR, FAULT_FILL_TO;
  - motor state encoding M_IDLE, M_FWD, M_REV, M_DEAD.
- Sub-module washer_motor_fsm contains the dead-time FSM.
  - Inputs: fwd_req, rev_req, force_idle.
  - Outputs: motor_fwd, motor_rev.
  - Parameter: DEADTIME.
- The level model and fault logic stay in the top module.

Test Plan (LEVEL_MAX=10, FILL_RATE=1, DRAIN_RATE=2, DEADTIME=3, FILL_TIMEOUT=4):
1. Reset release, no ctrl activity → all drives 0, level=0, level_empty=1, fault=0.
2. ctrl_fill held 15 cycles → valve_in high from cycle 1, level counts 1..10, level_full=1 at level 10, valve_in drops the next cycle. Fill-timeout fault code 3 after 4 further cycles.
3. From level=10 with faults cleared, ctrl_release held → level 8,6,4,2,0, level_empty=1, valve_out drops, level never underflows.
4. ctrl_forward for 5 cycles, then ctrl_reverse only → motor_fwd falls, both motor outputs low exactly 3 cycles, motor_rev rises on the 4th cycle.
5. ctrl_fill and ctrl_release high in the same cycle → fault=1, code 1 the next cycle, valves 0. clear_fault while the conflict persists is ignored; clear_fault after the conflict drops clears the fault.
6. Assert rst_n=0 mid-fill (level=5) during M_FWD → asynchronous return to reset values on the same edge, no clock required.
